// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset PC and the fetch-buffer entry type for the prefetch unit.
package ifu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RST_PC_DEF = 32'h8000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: consumer handshake, redirect and instruction-RAM port of the prefetch unit.
interface ifu_prefetch_if import ifu_pkg::*; #(parameter int ADDR_W = 15);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              ifu2ram_cs;
    logic              ifu2ram_w_en;
    logic [ADDR_W-1:0] ifu2ram_addr;
    logic [XLEN-1:0]   ifu2ram_din;
    modport master (
        output valid, pc, instr, ifu2ram_cs, ifu2ram_w_en, ifu2ram_addr,
        input  ready, redirect, redirect_pc, ifu2ram_din
    );
    modport slave (
        input  valid, pc, instr, ifu2ram_cs, ifu2ram_w_en, ifu2ram_addr,
        output ready, redirect, redirect_pc, ifu2ram_din
    );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush, count, full and empty.
module ifu_fifo import ifu_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    // a push at full is accepted only when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetcher feeding a DEPTH-entry buffer from a 1-cycle-latency RAM.
// Optional perf counters enabled by defining IFU_PREFETCH_PERF_EN.
module ifu_prefetch import ifu_pkg::*; #(
    parameter int              ADDR_W = 15,
    parameter int              DEPTH  = 4,
    parameter logic [XLEN-1:0] RST_PC = RST_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IFU_PREFETCH_PERF_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
`endif
    ifu_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0] fetch_pc, req_pc;
    logic            inflight, valid, transfer, cs, full, empty;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    fetch_entry_t    head;
    ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (inflight && !bus.redirect),
        .din   ('{pc: req_pc, instr: bus.ifu2ram_din}),
        .pop   (transfer),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign valid = !rst && !empty;
    assign transfer = valid && bus.ready;
    // slots already claimed by buffered entries plus the response still on its way
    assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign cs = !rst && !bus.redirect && (!full || transfer) &&
                (occ < (CW+1)'(DEPTH) + {{CW{1'b0}}, transfer});
    assign bus.valid = valid;
    assign bus.pc = valid ? head.pc : RST_PC;
    assign bus.instr = valid ? head.instr : '0;
    assign bus.ifu2ram_cs = cs;
    assign bus.ifu2ram_w_en = 1'b0;
    assign bus.ifu2ram_addr = fetch_pc[ADDR_W+1:2];
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RST_PC;
            req_pc <= RST_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= cs;
            fetch_pc <= bus.redirect ? bus.redirect_pc : cs ? fetch_pc + 32'd4 : fetch_pc;
            if (cs) req_pc <= fetch_pc;
        end
    end
`ifdef IFU_PREFETCH_PERF_EN
    logic [32:0] flush_sum;
    assign flush_sum = {1'b0, perf_flush_cnt} + 33'(count) + 33'(inflight) - 33'(transfer);
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + 32'(!valid && perf_stall_cyc != '1);
            if (bus.redirect) perf_flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: table-driven cycle vectors plus hand-written corner sequences for ifu_prefetch.
module tb_ifu_prefetch;
    import ifu_pkg::*;
    localparam logic [31:0] P = 32'h8000_0000;
    typedef struct {
        logic        r, rdy, rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        ecs;
        logic [14:0] eaddr;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    vec_t vq[$];
    ifu_prefetch_if #(.ADDR_W(15)) bus();
`ifdef IFU_PREFETCH_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
    ifu_prefetch #(.ADDR_W(15), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .bus(bus)
    );
`else
    ifu_prefetch #(.ADDR_W(15), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    always #5 clk = ~clk;
    function automatic logic [31:0] word_of(logic [14:0] a);
        return 32'hA000_0000 | {17'b0, a};
    endfunction
    // one-cycle-latency instruction RAM; idle cycles return a poison word
    always @(posedge clk) bus.ifu2ram_din <= bus.ifu2ram_cs ? word_of(bus.ifu2ram_addr) : 32'hDEAD_BEEF;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic add(logic r, logic rdy, logic rd, logic [31:0] rpc,
                       logic ev, logic [31:0] epc, logic ecs, logic [14:0] eaddr);
        vq.push_back('{r, rdy, rd, rpc, ev, epc, ecs, eaddr});
    endtask
    task automatic drive(logic r, logic rdy, logic rd, logic [31:0] rpc);
        rst = r;
        bus.ready = rdy;
        bus.redirect = rd;
        bus.redirect_pc = rpc;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n, ncs;
        logic [31:0] base;
        // reset, fill latency, redirect with transfer, wrap, mid-run reset
        add(1,1,0,0, 0,P,0,0);
        add(0,1,0,0, 0,0,1,15'h0);
        add(0,1,0,0, 0,0,1,15'h1);
        add(0,1,0,0, 1,P,1,15'h2);
        add(0,1,0,0, 1,P+4,1,15'h3);
        add(0,1,1,P+32'h100, 1,P+8,0,0);
        add(0,1,0,0, 0,0,1,15'h40);
        add(0,1,0,0, 0,0,1,15'h41);
        add(0,1,0,0, 1,P+32'h100,1,15'h42);
        add(0,1,0,0, 1,P+32'h104,1,15'h43);
        add(0,1,1,32'hFFFF_FFFC, 1,P+32'h108,0,0);
        add(0,1,0,0, 0,0,1,15'h7FFF);
        add(0,1,0,0, 0,0,1,15'h0);
        add(0,1,0,0, 1,32'hFFFF_FFFC,1,15'h1);
        add(0,1,0,0, 1,32'h0,1,15'h2);
        add(0,1,0,0, 1,32'h4,1,15'h3);
        add(1,1,0,0, 0,P,0,0);
        add(0,1,0,0, 0,0,1,15'h0);
        add(0,1,0,0, 0,0,1,15'h1);
        add(0,1,0,0, 1,P,1,15'h2);
        // ready low for 10 cycles: four requests then backpressure, head stable
        add(1,0,0,0, 0,P,0,0);
        add(0,0,0,0, 0,0,1,15'h0);
        add(0,0,0,0, 0,0,1,15'h1);
        add(0,0,0,0, 1,P,1,15'h2);
        add(0,0,0,0, 1,P,1,15'h3);
        for (int i = 0; i < 6; i++) add(0,0,0,0, 1,P,0,0);
        // redirect with 3 buffered and 1 in flight
        add(1,0,0,0, 0,P,0,0);
        add(0,0,0,0, 0,0,1,15'h0);
        add(0,0,0,0, 0,0,1,15'h1);
        add(0,0,0,0, 1,P,1,15'h2);
        add(0,0,0,0, 1,P,1,15'h3);
        add(0,0,1,P+32'h100, 1,P,0,0);
        add(0,1,0,0, 0,0,1,15'h40);
        add(0,1,0,0, 0,0,1,15'h41);
        add(0,1,0,0, 1,P+32'h100,1,15'h42);
        add(0,1,0,0, 1,P+32'h104,1,15'h43);
        add(0,1,0,0, 1,P+32'h108,1,15'h44);
        drive(1, 0, 0, 0);
        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].rdy, vq[i].rd, vq[i].rpc);
            @(negedge clk);
            chk($sformatf("v%0d valid", i), 32'(bus.valid), 32'(vq[i].ev));
            chk($sformatf("v%0d cs", i), 32'(bus.ifu2ram_cs), 32'(vq[i].ecs));
            chk($sformatf("v%0d w_en", i), 32'(bus.ifu2ram_w_en), 32'h0);
            if (vq[i].ev || vq[i].r) chk($sformatf("v%0d pc", i), bus.pc, vq[i].epc);
            if (vq[i].ev) chk($sformatf("v%0d instr", i), bus.instr, word_of(vq[i].epc[16:2]));
            if (vq[i].r) chk($sformatf("v%0d instr", i), bus.instr, 32'h0);
            if (vq[i].ecs) chk($sformatf("v%0d addr", i), 32'(bus.ifu2ram_addr), 32'(vq[i].eaddr));
            tick();
        end
        // throughput: bounded wait for the first word then one pc per cycle
        drive(1, 1, 0, 0);
        tick();
        rst = 1'b0;
        n = 0;
        while (!bus.valid && n < 5) begin
            tick();
            n++;
        end
        chk("wait valid", 32'(bus.valid), 32'h1);
        chk("first latency", n, 2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream pc%0d", i), bus.pc, P + 32'(4 * i));
            tick();
        end
        // backpressure: exactly DEPTH requests while ready is low
        drive(1, 0, 0, 0);
        tick();
        rst = 1'b0;
        ncs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ncs += int'(bus.ifu2ram_cs);
            tick();
        end
        chk("cs count", ncs, 4);
        chk("held pc", bus.pc, P);
        chk("held instr", bus.instr, word_of(15'h0));
`ifdef IFU_PREFETCH_PERF_EN
        drive(1, 0, 0, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        base = perf_flush_cnt;
        chk("flush after reset", base, 32'h0);
        chk("stall cycles", perf_stall_cyc, 32'd2);
        drive(0, 0, 1, P + 32'h100);
        tick();
        bus.redirect = 1'b0;
        chk("flush count", perf_flush_cnt, base + 32'd4);
`else
        base = 32'h0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter ADDR_W, default 15: instruction-RAM word-address width.
REQ-002 Parameter DEPTH, default 4: prefetch buffer entries; power of two, 2..16.
REQ-003 Parameter RST_PC, default 32'h8000_0000: fetch PC after reset.
REQ-004 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, in, 1: synchronous, active-high reset.
REQ-006 Port valid, out, 1: buffer head holds an instruction.
REQ-007 Port ready, in, 1: consumer accepts head this cycle.
REQ-008 Port pc, out, 32: PC of head instruction.
REQ-009 Port instr, out, 32: head instruction word.
REQ-010 Port redirect, in, 1: flush and restart fetch.
REQ-011 Port redirect_pc, in, 32: new fetch PC, word aligned.
REQ-012 Port ifu2ram_cs, out, 1: RAM read request.
REQ-013 Port ifu2ram_w_en, out, 1: RAM write enable, tied 0.
REQ-014 Port ifu2ram_addr, out, ADDR_W: word address, equal to fetch_pc[ADDR_W+1:2].
REQ-015 Port ifu2ram_din, in, 32: RAM read data, valid exactly one cycle after cs.

Function
REQ-016 A transfer SHALL occur on a cycle with valid=1 and ready=1; head pops at that edge.
REQ-017 A request SHALL issue (cs=1) when count + inflight + (transfer? -1 : 0) < DEPTH and redirect=0; fetch_pc then advances by 4.
REQ-018 Response data SHALL be written to the buffer one cycle after the request, tagged with the request's PC.
REQ-019 Fill-to-output latency SHALL be 2 cycles: cs at cycle N, valid=1 at cycle N+2 if buffer was empty.
REQ-020 With ready held 1 and no redirect, throughput SHALL be one instruction per cycle after the first.
REQ-021 Buffer SHALL never overflow; simultaneous push and pop at full SHALL be legal and keep count.
REQ-022 The head SHALL stay stable (pc, instr) while valid=1 and ready=0.
REQ-023 On redirect=1, the buffer SHALL be emptied, any in-flight response discarded, fetch_pc set to redirect_pc, and valid=0 in the next cycle.
REQ-024 A transfer coinciding with redirect SHALL complete; the head is consumed, and then the flush takes effect.
REQ-025 The first request after a redirect SHALL issue in the cycle after redirect, with addr taken from redirect_pc.
REQ-026 fetch_pc SHALL wrap modulo 2^32 with no error.
REQ-027 PC arithmetic SHALL be 32-bit unsigned; bits [1:0] of pc SHALL always be 0.

Reset
REQ-028 While rst=1: valid=0, cs=0, buffer empty, inflight=0, fetch_pc=RST_PC, pc=RST_PC, instr=0.
REQ-029 Reset asserted mid-operation SHALL discard buffered and in-flight data at the next edge.
REQ-030 The first request SHALL issue in the first cycle with rst=0.

Configuration
REQ-031 Macro IFU_PREFETCH_PERF_EN SHALL add outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
REQ-032 perf_stall_cyc counts cycles with valid=0 and rst=0.
REQ-033 perf_flush_cnt counts entries plus in-flight responses discarded by redirect.
REQ-034 Both counters SHALL saturate at all-ones and clear on rst.
REQ-035 Without the macro, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-036 Package ifu_pkg SHALL hold RST_PC default, XLEN=32, and the typedef for a {pc, instr} fetch entry.
REQ-037 Sub-module ifu_fifo SHALL implement the DEPTH-entry synchronous FIFO with flush, count, full and empty.

Verification
REQ-038 Reset release, ready=1 -> addr 0x0000 at cycle 0, valid=1 at cycle 2 with pc=0x8000_0000, then pc +4 per cycle.
REQ-039 ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, cs=0 afterwards, head pc=0x8000_0000 stable.
REQ-040 Redirect to 0x8000_0100 while full, with a response in flight -> next cycle valid=0; next pc delivered is 0x8000_0100; stale word never appears.
REQ-041 Redirect concurrent with transfer at head 0x8000_0008 -> 0x8000_0008 consumed once, then 0x8000_0100 stream.
REQ-042 Redirect to 0xFFFF_FFFC, ready=1 -> pcs 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-043 With IFU_PREFETCH_PERF_EN, a flush of 3 entries plus 1 in flight -> perf_flush_cnt increments by 4.
